// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel sampling multiplexer with manual select or
// dwell-timed auto-scan over an enable mask, feeding a valid/ready
// output register. Backpressure stalls the scan so no channel is skipped.
module mux_scan_n #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       chan_en,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan
);

  localparam int unsigned        CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             mode_q;
  logic             primed_q;

  logic [SEL_W-1:0] ptr_nxt;
  logic             any_en;
  int unsigned      idx;

  logic             slot_free;
  logic             terminal;
  logic             mode_chg;
  logic [SEL_W-1:0] tgt;
  logic             tgt_ok;
  logic             capture;

  // Next enabled channel strictly after ptr, wrapping; scanning offsets
  // downward so the nearest enabled index wins.
  always_comb begin
    ptr_nxt = ptr_q;
    any_en  = 1'b0;
    idx     = 0;
    for (int unsigned i = CHANNELS; i >= 1; i--) begin
      idx = (32'(ptr_q) + i) % CHANNELS;
      if (chan_en[idx]) begin
        ptr_nxt = SEL_W'(idx);
        any_en  = 1'b1;
      end
    end
  end

  // Slot action: dwell count, stall on backpressure, capture and ptr advance.
  always_comb begin
    slot_free = !valid_q || out_ready;
    terminal  = (cnt_q == CNT_LAST);
    // mode_q is only meaningful once loaded after reset; the first edge
    // must not look like a mode change or the first capture slips a slot.
    mode_chg  = primed_q && (mode != mode_q);
    tgt       = mode ? ptr_q : sel;
    tgt_ok    = mode ? chan_en[ptr_q] : (32'(sel) < CHANNELS);

    cnt_d   = cnt_q + CNT_W'(1);
    ptr_d   = ptr_q;
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    chan_d  = chan_q;
    capture = 1'b0;

    if (mode_chg) begin
      cnt_d = '0;
    end else if (terminal) begin
      if (!slot_free) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d   = '0;
        capture = tgt_ok;
        if (mode && any_en) ptr_d = ptr_nxt;
      end
    end

    if (capture) begin
      valid_d = 1'b1;
      data_d  = in_data[32'(tgt)*WIDTH +: WIDTH];
      chan_d  = tgt;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      chan_q   <= '0;
      mode_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
      mode_q   <= mode;
      primed_q <= 1'b1;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n (8 channels x 4 bits, dwell 4, channel k = k+1),
// plus a dwell-1 instance sharing the same stimulus.
module tb_mux_scan_n;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mode;
  logic [2:0]  sel;
  logic [31:0] in_data;
  logic [7:0]  chan_en;
  logic        out_ready;

  logic        out_valid;
  logic [3:0]  out_data;
  logic [2:0]  out_chan;
  logic        d1_valid;
  logic [3:0]  d1_data;
  logic [2:0]  d1_chan;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_scan_n #(.CHANNELS(8), .WIDTH(4), .SEL_W(3), .DWELL(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .in_data(in_data),
    .chan_en(chan_en), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan)
  );

  mux_scan_n #(.CHANNELS(8), .WIDTH(4), .SEL_W(3), .DWELL(1)) dut1 (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .in_data(in_data),
    .chan_en(chan_en), .out_ready(out_ready),
    .out_valid(d1_valid), .out_data(d1_data), .out_chan(d1_chan)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_sample(input string tag, input int ch);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".chan"}, 32'(out_chan), 32'(ch));
    check({tag, ".data"}, 32'(out_data), 32'(ch + 1));
  endtask

  // Called 1 time unit after a rising edge; releases reset before the next one.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    check({tag, ".rst_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".rst_data"}, 32'(out_data), 32'd0);
    check({tag, ".rst_chan"}, 32'(out_chan), 32'd0);
    check({tag, ".rst_d1_valid"}, 32'(d1_valid), 32'd0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    in_data   = 32'h8765_4321;
    mode      = 1'b1;
    sel       = 3'd0;
    chan_en   = 8'hFF;
    out_ready = 1'b1;
    tick();

    // Full auto-scan, all channels enabled
    do_reset("A");
    tick();
    check("A.d1_e1_chan", 32'(d1_chan), 32'd0);
    check("A.d1_e1_valid", 32'(d1_valid), 32'd1);
    tick();
    check("A.d1_e2_chan", 32'(d1_chan), 32'd1);
    tick();
    check("A.d1_e3_chan", 32'(d1_chan), 32'd2);
    check("A.d1_e3_data", 32'(d1_data), 32'd3);
    check("A.e3_valid", 32'(out_valid), 32'd0);
    tick();
    expect_sample("A.e4", 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("A.cleared", 32'(out_valid), 32'd0);
      ticks(3);
      expect_sample("A.slot", k % 8);
    end

    // Sparse enable mask: 2,5,7,2
    chan_en = 8'b1010_0100;
    tick();
    do_reset("B");
    ticks(4);
    check("B.e4_valid", 32'(out_valid), 32'd0);
    ticks(4);
    expect_sample("B.e8", 2);
    ticks(4);
    expect_sample("B.e12", 5);
    ticks(4);
    expect_sample("B.e16", 7);
    ticks(4);
    expect_sample("B.e20", 2);

    // Backpressure stall, single-cycle release, then reset mid-stall
    chan_en = 8'hFF;
    tick();
    do_reset("C");
    ticks(4);
    expect_sample("C.e4", 0);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_sample("C.stall", 0);
    end
    out_ready = 1'b1;
    tick();
    expect_sample("C.release", 1);
    out_ready = 1'b0;
    ticks(3);
    expect_sample("C.hold", 1);
    do_reset("C2");
    out_ready = 1'b1;
    ticks(3);
    check("C2.e3_valid", 32'(out_valid), 32'd0);
    tick();
    expect_sample("C2.e4", 0);

    // Manual select, mode switches with ptr retained
    tick();
    do_reset("D");
    ticks(4);
    expect_sample("D.e4", 0);
    ticks(4);
    expect_sample("D.e8", 1);
    mode    = 1'b0;
    sel     = 3'd3;
    chan_en = 8'h00;
    tick();
    check("D.chg_valid", 32'(out_valid), 32'd0);
    ticks(3);
    check("D.e12_valid", 32'(out_valid), 32'd0);
    tick();
    expect_sample("D.man1", 3);
    ticks(4);
    expect_sample("D.man2", 3);
    mode    = 1'b1;
    chan_en = 8'hFF;
    tick();
    check("D.chg2_valid", 32'(out_valid), 32'd0);
    ticks(4);
    expect_sample("D.auto1", 2);
    ticks(4);
    expect_sample("D.auto2", 3);

    // No channel enabled: never valid
    chan_en = 8'h00;
    tick();
    do_reset("E");
    for (int i = 0; i < 100; i++) begin
      tick();
      check("E.idle_valid", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_n.md
MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 Parameter CHANNELS, default 8: number of input channels, legal range 2..256.
REQ-002 Parameter WIDTH, default 1: bits per channel, legal range 1..32.
REQ-003 Parameter SEL_W, default 3: channel index width; SHALL equal ceil(log2(CHANNELS)).
REQ-004 Parameter DWELL, default 4: cycles per channel slot, legal range 1..65535.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 mode  in  1  0 = manual select, 1 = auto-scan.
REQ-008 sel  in  SEL_W  manual channel index.
REQ-009 in_data  in  CHANNELS*WIDTH  packed channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-010 chan_en  in  CHANNELS  auto-scan inclusion mask; bit k enables channel k.
REQ-011 out_ready  in  1  consumer accepts the current sample.
REQ-012 out_valid  out  1  out_data/out_chan hold an unconsumed sample.
REQ-013 out_data  out  WIDTH  captured channel value.
REQ-014 out_chan  out  SEL_W  index of the captured channel.

Function
REQ-015 Internal state: dwell counter cnt (0..DWELL-1), auto pointer ptr (0..CHANNELS-1), output register (out_valid, out_data, out_chan).
REQ-016 Slot free = !out_valid or out_ready, evaluated in the same cycle.
REQ-017 cnt increments by 1 each cycle while cnt < DWELL-1; at DWELL-1 ("terminal") it evaluates the slot action below.
REQ-018 Target channel: manual mode -> sel; auto mode -> ptr.
REQ-019 Terminal, slot free, target valid: the edge captures out_data <= in_data[target], out_chan <= target, out_valid <= 1, cnt <= 0.
REQ-020 Target valid: manual mode -> sel < CHANNELS; auto mode -> chan_en[ptr] = 1.
REQ-021 Terminal, target invalid: no capture, cnt <= 0, out_valid unaffected except by REQ-024.
REQ-022 Terminal, slot not free: cnt holds at DWELL-1, ptr holds, no capture (backpressure stalls the scan; no channel is skipped).
REQ-023 Auto mode: ptr advances, on every terminal edge not stalled by REQ-022, to the next index above ptr with chan_en set, wrapping CHANNELS-1 -> 0; chan_en all zero -> ptr holds and no capture occurs.
REQ-024 out_valid & out_ready at an edge clears out_valid unless the same edge captures, in which case out_valid stays 1 with the new sample.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_chan SHALL stay stable.
REQ-026 A change of mode forces cnt <= 0 on the next edge with no capture that edge; ptr is retained.
REQ-027 Manual mode: ptr is frozen; chan_en is ignored.
REQ-028 DWELL=1: every cycle is terminal, so one capture per cycle when the slot is free.
REQ-029 Capture latency: sample present on outputs immediately after the capturing edge; in_data is sampled at that edge only.

Reset
REQ-030 reset=1 SHALL immediately, without waiting for clk, force out_valid=0, out_data=0, out_chan=0, cnt=0, ptr=0.
REQ-031 After reset deasserts, the first capture occurs at the DWELL-th rising edge, provided the slot is free and the target is valid.
REQ-032 Reset asserted mid-slot or mid-stall discards the pending sample and any partial count.

Verification (CHANNELS=8, WIDTH=4, DWELL=4, channel k driven with k+1)
REQ-033 Auto, chan_en=8'hFF, out_ready=1 -> one capture every 4 cycles, out_chan 0,1,...,7,0, out_data = out_chan+1.
REQ-034 Auto, chan_en=8'b1010_0100 -> out_chan sequence 2,5,7,2, each 4 cycles apart; out_data 3,6,8,3.
REQ-035 Auto, out_ready=0 after the first capture (chan 0) -> out_valid stays 1 with data 1 and no further capture; then out_ready=1 for one cycle -> that edge captures chan 1 and out_valid stays 1.
REQ-036 Manual, sel=3 -> out_chan=3, out_data=4 every 4 cycles; switch to mode=1 -> one cycle without capture, then a capture every 4 cycles from the retained ptr.
REQ-037 Auto, chan_en=0 -> out_valid stays 0 for 100 cycles.
REQ-038 reset pulsed between edges during an out_valid=1 stall -> all outputs 0 before the next edge; after release the first capture is chan 0 at the 4th edge.
